// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction fetch and data port
// Optional build macro MEMARB_FAIR_EN: alternate I/D grants under contention
// (default build: data side has strict priority).
module mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, DONE_I, DONE_D} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] store_q;
  logic              wr_q;
  logic              ren_q;
  logic              wen_q;
  logic [WORD_W-1:0] iload_q;
  logic [WORD_W-1:0] dload_q;
  logic              err_q;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;
  logic              to_hit;
  logic              ireq;
  logic              dreq;
  logic              pick_d;

  assign ireq = iREN;
  assign dreq = dREN | dWEN;

`ifdef MEMARB_FAIR_EN
  logic last_d_q;

  // Under contention the side that did not win last time gets the grant.
  assign pick_d = dreq & (~ireq | ~last_d_q);

  // Remember which side was granted most recently (0 = instruction).
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_d_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (pick_d) begin
        last_d_q <= 1'b1;
      end else if (ireq) begin
        last_d_q <= 1'b0;
      end
    end
  end
`else
  assign pick_d = dreq;
`endif

  // Timeout bookkeeping for the grant states.
  always_comb begin
    cnt_d  = cnt_q + 16'd1;
    to_hit = (cnt_q == CNT_LAST);
  end

  // Completion is visible only in the single DONE cycle of the matching side.
  assign iwait = ireq & (state_q != DONE_I);
  assign dwait = dreq & (state_q != DONE_D);

  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign err      = err_q;

  // Arbitration FSM; RAM strobes and load data are registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            addr_q  <= daddr;
            store_q <= dstore;
            wr_q    <= dWEN;
            ren_q   <= ~dWEN;
            wen_q   <= dWEN;
            cnt_q   <= '0;
            state_q <= GNT_D;
          end else if (ireq) begin
            addr_q  <= iaddr;
            wr_q    <= 1'b0;
            ren_q   <= 1'b1;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= GNT_I;
          end
        end
        GNT_I, GNT_D: begin
          if (ramready || to_hit) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
            // A stuck RAM completes with zero read data and an error pulse.
            err_q   <= ~ramready;
            if (state_q == GNT_I) begin
              iload_q <= ramready ? ramload : '0;
              state_q <= DONE_I;
            end else begin
              if (!wr_q) begin
                dload_q <= ramready ? ramload : '0;
              end
              state_q <= DONE_D;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with random traffic
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        err;

  mem_arbiter #(.WORD_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] load;
    logic        err;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] ram_mem[64];
  logic [31:0] ref_mem[64];
  logic [31:0] exp_dload;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          ram_auto = 0;
  bit          mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // RAM model: per access picks a delay; address bit 12 means never answer.
  initial begin
    logic        busy;
    logic        stall;
    int          cnt;
    int          dly;
    logic [31:0] a0;
    busy = 0; stall = 0; cnt = 0; dly = 0; a0 = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (ram_auto) begin
        if (ramREN || ramWEN) begin
          if (!busy) begin
            busy  = 1;
            cnt   = 0;
            dly   = $urandom_range(0, 4);
            a0    = ramaddr;
            stall = ramaddr[12];
            chk("ram_one_strobe", 32'(ramREN & ramWEN), 32'd0);
          end else begin
            chk("ramaddr_stable", ramaddr, a0);
          end
          if (!stall && cnt == dly) begin
            ramready = 1'b1;
            if (ramREN) ramload = ram_mem[ramaddr[7:2]];
            else ram_mem[ramaddr[7:2]] = ramstore;
          end else begin
            ramready = 1'b0;
            ramload  = $urandom;
          end
          cnt++;
        end else begin
          busy     = 0;
          ramready = 1'b0;
          ramload  = $urandom;
        end
      end
    end
  end

  // Monitor: every completion seen by an asserting requester is scored.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (iREN && !iwait) begin
          if (iq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL i_unexpected_done: got completion expected none");
          end else begin
            e = iq.pop_front();
            chk("i_load", iload, e.load);
            chk("i_err", 32'(err), 32'(e.err));
          end
        end
        if ((dREN || dWEN) && !dwait) begin
          if (dq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL d_unexpected_done: got completion expected none");
          end else begin
            e = dq.pop_front();
            chk("d_load", dload, e.load);
            chk("d_err", 32'(err), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic i_driver(input int n);
    int   idx;
    bit   stall;
    int   w;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      iREN = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      idx   = $urandom_range(0, 31);
      stall = ($urandom_range(0, 7) == 0);
      iaddr = (32'(stall) << 12) | (32'(idx) << 2);
      e.err  = stall;
      e.load = stall ? 32'd0 : ref_mem[idx];
      iq.push_back(e);
      iREN = 1'b1;
      w = 0;
      forever begin
        smp();
        if (!iwait) break;
        w++;
        if (w > 60) begin
          n_checks++; n_fail++;
          $display("FAIL i_done_timeout: got no completion expected one within 60 cycles");
          break;
        end
      end
      tick();
    end
    iREN = 1'b0;
  endtask

  task automatic d_driver(input int n);
    int   idx;
    bit   stall;
    int   op;
    int   w;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      dREN = 1'b0;
      dWEN = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      idx    = $urandom_range(32, 63);
      stall  = ($urandom_range(0, 7) == 0);
      op     = $urandom_range(0, 2);
      daddr  = (32'(stall) << 12) | (32'(idx) << 2);
      dstore = $urandom;
      if (op == 0) begin
        if (!stall) exp_dload = ref_mem[idx];
        else exp_dload = 32'd0;
      end else if (!stall) begin
        ref_mem[idx] = dstore;
      end
      e.err  = stall;
      e.load = exp_dload;
      dq.push_back(e);
      dREN = (op != 1);
      dWEN = (op != 0);
      w = 0;
      forever begin
        smp();
        if (!dwait) break;
        w++;
        if (w > 60) begin
          n_checks++; n_fail++;
          $display("FAIL d_done_timeout: got no completion expected one within 60 cycles");
          break;
        end
      end
      tick();
    end
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    RST = 1'b1; iREN = 1'b1; iaddr = '0; dREN = 1'b0; dWEN = 1'b1;
    daddr = 32'h100; dstore = 32'h5; ramready = 1'b0; ramload = '0;

    // reset with requests held
    tick(); tick();
    smp();
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_err", 32'(err), 0);
    tick();
    RST = 1'b0;
    smp();
    chk("rst_fall_idle", 32'(ramWEN), 0);
    tick();
    smp();
    chk("first_grant_wen", 32'(ramWEN), 1);
    chk("first_grant_addr", ramaddr, 32'h100);
    iREN = 0; dWEN = 0; ramready = 1;
    tick(); ramready = 0;
    tick();

    // instruction read, RAM ready immediately
    iREN = 1; iaddr = 32'h40; ramready = 1; ramload = 32'hDEADBEEF;
    smp(); chk("ird_wait_T", 32'(iwait), 1);
    tick(); smp();
    chk("ird_ren", 32'(ramREN), 1);
    chk("ird_addr", ramaddr, 32'h40);
    chk("ird_wait_T1", 32'(iwait), 1);
    tick(); smp();
    chk("ird_wait_T2", 32'(iwait), 0);
    chk("ird_load", iload, 32'hDEADBEEF);
    iREN = 0; ramready = 0;
    tick();

    // contention: data first, then instruction
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
    ramready = 1; ramload = 32'hCAFE0001;
    tick(); smp();
    chk("cont_wen", 32'(ramWEN), 1);
    chk("cont_ren", 32'(ramREN), 0);
    chk("cont_store", ramstore, 32'h12345678);
    chk("cont_daddr", ramaddr, 32'h80);
    tick(); smp();
    chk("cont_dwait", 32'(dwait), 0);
    chk("cont_iwait", 32'(iwait), 1);
    dWEN = 0;
    tick(); smp();
    chk("cont_idle", 32'(ramREN), 0);
    tick(); smp();
    chk("cont_i_ren", 32'(ramREN), 1);
    chk("cont_i_addr", ramaddr, 32'h44);
    tick(); smp();
    chk("cont_i_wait", 32'(iwait), 0);
    chk("cont_i_load", iload, 32'hCAFE0001);
    iREN = 0; ramready = 0;
    tick();

    // wait states with daddr changing mid-grant
    dREN = 1; daddr = 32'h200; ramload = 32'h5A5A;
    tick();
    daddr = 32'h300;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("ws_ren", 32'(ramREN), 1);
      chk("ws_addr", ramaddr, 32'h200);
      chk("ws_dwait", 32'(dwait), 1);
      tick();
      if (k == 3) ramready = 1;
    end
    smp();
    chk("ws_done_wait", 32'(dwait), 0);
    chk("ws_load", dload, 32'h5A5A);
    chk("ws_ren_off", 32'(ramREN), 0);
    dREN = 0; ramready = 0;
    tick();

    // timeout on a stuck RAM
    dREN = 1; daddr = 32'h400;
    tick();
    for (int k = 0; k < TO; k++) begin
      smp();
      chk("to_grant", {30'd0, ramREN, dwait}, 32'h3);
      chk("to_err_low", 32'(err), 0);
      tick();
    end
    smp();
    chk("to_err", 32'(err), 1);
    chk("to_dwait", 32'(dwait), 0);
    chk("to_dload", dload, 0);
    chk("to_ren_off", 32'(ramREN), 0);
    dREN = 0;
    tick(); smp();
    chk("to_err_clear", 32'(err), 0);

    // read and write together is a write
    tick();
    dREN = 1; dWEN = 1; daddr = 32'h500; dstore = 32'h77; ramready = 1;
    tick(); smp();
    chk("dual_wen", 32'(ramWEN), 1);
    chk("dual_ren", 32'(ramREN), 0);
    chk("dual_store", ramstore, 32'h77);
    tick(); smp();
    chk("dual_dwait", 32'(dwait), 0);
    chk("dual_dload", dload, 0);
    dREN = 0; dWEN = 0; ramready = 0;
    tick();

    // instruction request dropped mid-grant
    iREN = 1; iaddr = 32'h600; ramload = 32'h99;
    tick(); smp();
    chk("drop_ren", 32'(ramREN), 1);
    tick();
    iREN = 0; ramready = 1;
    smp(); chk("drop_iwait", 32'(iwait), 0);
    tick(); smp();
    chk("drop_load", iload, 32'h99);
    chk("drop_ren_off", 32'(ramREN), 0);
    ramready = 0;
    tick();
    iREN = 1; iaddr = 32'h604; ramload = 32'h1234; ramready = 1;
    tick(); smp();
    chk("after_drop_addr", ramaddr, 32'h604);
    tick(); smp();
    chk("after_drop_wait", 32'(iwait), 0);
    chk("after_drop_load", iload, 32'h1234);
    iREN = 0; ramready = 0;
    tick();

    // random mixed traffic against the reference model
    exp_dload = 32'd0;
    ram_auto = 1;
    mon_en = 1;
    fork
      i_driver(120);
      d_driver(120);
    join
    repeat (4) tick();
    chk("iq_drained", 32'(iq.size()), 0);
    chk("dq_drained", 32'(dq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single-ported RAM shared between the instruction-fetch port and the data port of the CPU.
- Accepts level-held read/write requests from both sides and grants one transaction at a time.
- Drives the RAM control signals from registered, latched request fields; the RAM completes an access with a ramready handshake.
- Returns read data and a one-cycle completion (wait low) to the winning requester; a timeout counter bounds a stuck RAM.

Parameters:
WORD_W, 32, data word width
ADDR_W, 32, address width
TIMEOUT, 255, max cycles in a grant state without ramready before forced completion (1..2^16-1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
iREN  input  1  instruction read request, held until iwait low
iaddr  input  ADDR_W  instruction address
iwait  output  1  1 = instruction access not complete this cycle
iload  output  WORD_W  instruction read data, valid when iwait low
dREN  input  1  data read request
dWEN  input  1  data write request
daddr  input  ADDR_W  data address
dstore  input  WORD_W  data write value
dwait  output  1  1 = data access not complete this cycle
dload  output  WORD_W  data read data, valid when dwait low
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  ADDR_W  RAM address
ramstore  output  WORD_W  RAM write data
ramload  input  WORD_W  RAM read data, valid with ramready
ramready  input  1  RAM access complete this cycle
err  output  1  pulses 1 cycle with the completion of a timed-out access

Behaviour:
- Reset is synchronous on RST high:
  - state = IDLE, all latched fields = 0, timeout counter = 0.
  - ramREN = ramWEN = 0, ramaddr = ramstore = 0, iload = dload = 0, err = 0.
- iwait/dwait are combinational: xwait = xreq & ~(state == DONE_x), where ireq = iREN and dreq = dREN|dWEN.
- Each wait is 0 when the corresponding side has no request.
- States: IDLE, GNT_I, GNT_D, DONE_I, DONE_D.
- IDLE:
  - If dreq, latch daddr, dstore and op; go to GNT_D.
  - Else if ireq, latch iaddr; go to GNT_I.
  - Else stay in IDLE.
  - Data has strict priority.
- Op encoding: dWEN takes precedence over dREN when both are high (the access is treated as a write).
- GNT_x:
  - ramREN/ramWEN/ramaddr/ramstore are driven from the latched fields; strobes are low in all other states.
  - The counter increments each cycle.
  - On ramready: capture ramload into xload (reads only; writes leave dload unchanged), clear the counter, go to DONE_x.
  - If the counter reaches TIMEOUT-1 without ramready: go to DONE_x with err = 1 in DONE_x and xload = 0 for a read.
- DONE_x:
  - Lasts exactly one cycle; xwait = 0 if the request is still high.
  - Next state is always IDLE, so the requester sees the edge and drops or changes its request before re-arbitration.
- Latency: with ramready in the first grant cycle, a request at cycle T gives GNT at T+1 and wait low at T+2. Each extra RAM wait cycle adds 1.
- Request dropped mid-grant: the access still completes on the RAM. Load data is captured but no wait-low is presented (the requester is not asserting). Then IDLE.
- Request inputs changing during a grant have no effect on the RAM signals, which come only from latched values.
- iload/dload hold their last value between accesses.
- ramready outside GNT states is ignored.
- Back-to-back: a held or new request is re-arbitrated in the IDLE cycle after DONE, giving a minimum 3-cycle pitch.

Optional Feature:
- Macro: MEMARB_FAIR_EN.
- Defined: a 1-bit last_grant register (reset = I) is updated on entry to each GNT state. In IDLE with both requests pending, the side not granted last wins, so I and D alternate under contention.
- Not defined: strict data priority as above; no last_grant register exists.

Test Plan:
- Reset: hold RST 2 cycles with iREN = dWEN = 1 -> all RAM strobes 0, iload = dload = 0, err = 0. First grant occurs in the cycle after RST falls +1.
- Instruction read, ramready same cycle as grant: iREN = 1, iaddr = 0x40, ramload = 0xDEADBEEF -> ramREN = 1 and ramaddr = 0x40 at T+1; iwait = 0 and iload = 0xDEADBEEF at T+2.
- Contention: iREN = dWEN = 1 together, daddr = 0x80, dstore = 0x12345678 -> data granted first (ramWEN = 1, ramstore = 0x12345678), then instruction. With MEMARB_FAIR_EN and a repeated contention, the second arbitration goes to I.
- Wait states: dREN = 1, ramready delayed 4 cycles -> ramREN held 5 cycles, dwait = 1 throughout, dwait = 0 one cycle after ramready, and ramaddr stable even if daddr changes mid-grant.
- Timeout: TIMEOUT = 8, ramready tied 0, dREN = 1 -> GNT_D for 8 cycles, then err = 1 and dwait = 0 for one cycle with dload = 0, then IDLE.
- Dual op and drop: dREN = dWEN = 1 -> write performed, ramREN = 0. A separate iREN dropped during GNT_I -> access completes, iwait stays 0, no DONE pulse seen by the requester, next request served normally.
